// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, I/O register offsets
// and the default base address of the I/O window.
package memory_responder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   localparam logic [1:0] IO_LED     = 2'd0;
   localparam logic [1:0] IO_SWITCH  = 2'd1;
   localparam logic [1:0] IO_COUNTER = 2'd2;

   localparam logic [15:0] DEFAULT_IO_BASE = 16'hFF00;

endpackage

// File: rtl/memory_address_decoder.sv
// Combinational address decode for the memory responder: RAM, I/O window or unmapped.
// MEMORY_RESPONDER_CYCLE_COUNTER_EN makes IO_BASE+2 a readable counter; otherwise it is an error.
module memory_address_decoder
   import memory_responder_pkg::*;
#(
   parameter int                    DATA_WIDTH        = 16,
   parameter int                    RAM_ADDRESS_WIDTH = 14,
   parameter logic [DATA_WIDTH-1:0] IO_BASE           = DEFAULT_IO_BASE
) (
   input  logic [DATA_WIDTH-1:0] address,
   input  logic                  write,
   output logic                  is_ram,
   output logic                  is_io,
   output logic [1:0]            io_offset,
   output logic                  error
);

   logic [DATA_WIDTH-1:0] io_delta;

   // NOTE: every output gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      io_delta  = address - IO_BASE;
      is_ram    = (address >> RAM_ADDRESS_WIDTH) == '0;
      is_io     = !is_ram && (io_delta[DATA_WIDTH-1:2] == '0);
      io_offset = io_delta[1:0];
      error     = 1'b0;

      if (!is_ram && !is_io) begin
         error = 1'b1;
      end else if (is_io) begin
         case (io_offset)
            IO_LED:     error = 1'b0;
            IO_SWITCH:  error = write;
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
            IO_COUNTER: error = write;
`else
            IO_COUNTER: error = 1'b1;
`endif
            default:    error = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Valid/ready memory responder between the CPU request port, a synchronous block RAM and
// a small I/O window (LEDs, switches, cycle counter under MEMORY_RESPONDER_CYCLE_COUNTER_EN).
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int                    DATA_WIDTH        = 16,
   parameter int                    RAM_ADDRESS_WIDTH = 14,
   parameter logic [DATA_WIDTH-1:0] IO_BASE           = DEFAULT_IO_BASE
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         request_valid,
   output logic                         request_ready,
   input  logic                         request_write,
   input  logic [DATA_WIDTH-1:0]        request_address,
   input  logic [DATA_WIDTH-1:0]        request_write_data,
   output logic                         response_valid,
   input  logic                         response_ready,
   output logic [DATA_WIDTH-1:0]        response_read_data,
   output logic                         response_error,
   output logic [RAM_ADDRESS_WIDTH-1:0] ram_address,
   output logic                         ram_write_enable,
   output logic [DATA_WIDTH-1:0]        ram_write_data,
   input  logic [DATA_WIDTH-1:0]        ram_read_data,
   input  logic [DATA_WIDTH-1:0]        switches,
   output logic [DATA_WIDTH-1:0]        leds
);

   state_t                state;
   state_t                next_state;
   logic                  held_write;
   logic [DATA_WIDTH-1:0] held_address;
   logic [DATA_WIDTH-1:0] held_write_data;
   logic                  is_ram;
   logic                  is_io;
   logic [1:0]            io_offset;
   logic                  decode_error;
   logic [DATA_WIDTH-1:0] io_read_data;
   logic                  accept;
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
   logic [DATA_WIDTH-1:0] counter;
`endif

   memory_address_decoder #(
      .DATA_WIDTH       (DATA_WIDTH),
      .RAM_ADDRESS_WIDTH(RAM_ADDRESS_WIDTH),
      .IO_BASE          (IO_BASE)
   ) u_decoder (
      .address  (held_address),
      .write    (held_write),
      .is_ram   (is_ram),
      .is_io    (is_io),
      .io_offset(io_offset),
      .error    (decode_error)
   );

   assign accept         = (state == IDLE) && request_valid;
   assign ram_address    = held_address[RAM_ADDRESS_WIDTH-1:0];
   assign ram_write_data = held_write_data;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state       = state;
      request_ready    = 1'b0;
      response_valid   = 1'b0;
      ram_write_enable = 1'b0;
      case (state)
         IDLE: begin
            request_ready = 1'b1;
            if (request_valid) next_state = ACCESS;
         end
         ACCESS: begin
            if (is_ram) begin
               // Gated by reset so an in-flight store never lands during the reset cycle.
               ram_write_enable = held_write && !reset;
               next_state       = held_write ? RESPOND : WAIT;
            end else begin
               next_state = RESPOND;
            end
         end
         WAIT: next_state = RESPOND;
         RESPOND: begin
            response_valid = 1'b1;
            if (response_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         held_write      <= 1'b0;
         held_address    <= '0;
         held_write_data <= '0;
      end else if (accept) begin
         held_write      <= request_write;
         held_address    <= request_address;
         held_write_data <= request_write_data;
      end
   end

   always_comb begin
      io_read_data = '0;
      case (io_offset)
         IO_LED:     io_read_data = leds;
         IO_SWITCH:  io_read_data = switches;
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
         IO_COUNTER: io_read_data = counter;
`endif
         default:    io_read_data = '0;
      endcase
   end

   // Errors and stores respond with zero data; only clean I/O reads and RAM reads load data.
   always_ff @(posedge clock) begin
      if (reset) begin
         response_read_data <= '0;
         response_error     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  response_read_data <= '0;
                  response_error     <= 1'b0;
               end
            end
            ACCESS: begin
               response_error     <= decode_error;
               response_read_data <= (is_io && !held_write && !decode_error) ? io_read_data : '0;
            end
            WAIT:    response_read_data <= ram_read_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         leds <= '0;
      end else if (state == ACCESS && is_io && held_write && !decode_error && io_offset == IO_LED) begin
         leds <= held_write_data;
      end
   end

`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
   always_ff @(posedge clock) begin
      if (reset) counter <= '0;
      else       counter <= counter + 1'b1;
   end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder with a behavioural synchronous RAM.
// Build with MEMORY_RESPONDER_CYCLE_COUNTER_EN defined to exercise the counter register.
module tb_memory_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        request_valid;
   logic        request_ready;
   logic        request_write;
   logic [15:0] request_address;
   logic [15:0] request_write_data;
   logic        response_valid;
   logic        response_ready;
   logic [15:0] response_read_data;
   logic        response_error;
   logic [13:0] ram_address;
   logic        ram_write_enable;
   logic [15:0] ram_write_data;
   logic [15:0] ram_read_data;
   logic [15:0] switches;
   logic [15:0] leds;

   logic [15:0] ram_model [0:16383];
   int          strobes = 0;
   int          checks  = 0;
   int          errors  = 0;

   always #5 clock = ~clock;

   memory_responder dut (
      .clock             (clock),
      .reset             (reset),
      .request_valid     (request_valid),
      .request_ready     (request_ready),
      .request_write     (request_write),
      .request_address   (request_address),
      .request_write_data(request_write_data),
      .response_valid    (response_valid),
      .response_ready    (response_ready),
      .response_read_data(response_read_data),
      .response_error    (response_error),
      .ram_address       (ram_address),
      .ram_write_enable  (ram_write_enable),
      .ram_write_data    (ram_write_data),
      .ram_read_data     (ram_read_data),
      .switches          (switches),
      .leds              (leds)
   );

   initial begin
      for (int i = 0; i < 16384; i++) ram_model[i] = 16'h0000;
      ram_read_data = 16'h0000;
   end

   always @(posedge clock) begin
      if (ram_write_enable) begin
         ram_model[ram_address] <= ram_write_data;
         strobes                <= strobes + 1;
      end
      ram_read_data <= ram_model[ram_address];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=hang required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents a request and returns #1 after the accept edge, with the DUT in ACCESS.
   task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
      int guard;
      guard              = 0;
      request_valid      = 1'b1;
      request_write      = wr;
      request_address    = addr;
      request_write_data = wd;
      while (!request_ready && guard < 20) begin
         @(posedge clock); #1;
         guard++;
      end
      check("request_ready_in_idle", request_ready, 1'b1);
      @(posedge clock); #1;
      request_valid = 1'b0;
   endtask

   // Latency counts from the accept cycle T, so the first ACCESS cycle is 1.
   task automatic await_response(output int lat, output logic [15:0] data, output logic err);
      lat = 1;
      while (!response_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      data = response_read_data;
      err  = response_error;
   endtask

   task automatic release_response();
      response_ready = 1'b1;
      @(posedge clock); #1;
      response_ready = 1'b0;
   endtask

   task automatic transact(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int exp_lat,
                           input logic [15:0] exp_data, input logic exp_err);
      int          lat;
      logic [15:0] data;
      logic        err;
      issue(wr, addr, wd);
      await_response(lat, data, err);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_data"}, data, exp_data);
      check({tag, "_error"}, err, exp_err);
      release_response();
   endtask

   initial begin
      int          lat;
      logic [15:0] data;
      logic        err;
      int          strobes_before;

      reset              = 1'b1;
      request_valid      = 1'b0;
      request_write      = 1'b0;
      request_address    = 16'h0000;
      request_write_data = 16'h0000;
      response_ready     = 1'b0;
      switches           = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      check("reset_request_ready", request_ready, 1'b1);
      check("reset_response_valid", response_valid, 1'b0);
      check("reset_read_data", response_read_data, 16'h0000);
      check("reset_error", response_error, 1'b0);
      check("reset_ram_address", ram_address, 14'h0000);
      check("reset_ram_we", ram_write_enable, 1'b0);
      check("reset_ram_wdata", ram_write_data, 16'h0000);
      check("reset_leds", leds, 16'h0000);

      strobes_before = strobes;
      transact("ram_write_0010", 1'b1, 16'h0010, 16'h1234, 2, 16'h0000, 1'b0);
      check("ram_write_strobe", strobes, strobes_before + 1);
      transact("ram_read_0010", 1'b0, 16'h0010, 16'h0000, 3, 16'h1234, 1'b0);

      transact("ram_write_top", 1'b1, 16'h3FFF, 16'hCAFE, 2, 16'h0000, 1'b0);
      transact("ram_read_top", 1'b0, 16'h3FFF, 16'h0000, 3, 16'hCAFE, 1'b0);
      check("ram_model_top", ram_model[14'h3FFF], 16'hCAFE);

      strobes_before = strobes;
      issue(1'b1, 16'hFF00, 16'h00A5);
      await_response(lat, data, err);
      check("led_write_latency", lat, 2);
      check("led_write_error", err, 1'b0);
      check("led_after_access", leds, 16'h00A5);
      release_response();
      check("led_write_no_strobe", strobes, strobes_before);
      transact("led_read", 1'b0, 16'hFF00, 16'h0000, 2, 16'h00A5, 1'b0);

      switches = 16'hBEEF;
      transact("switch_read", 1'b0, 16'hFF01, 16'h0000, 2, 16'hBEEF, 1'b0);
      transact("switch_write", 1'b1, 16'hFF01, 16'h1111, 2, 16'h0000, 1'b1);
      check("switch_write_leds_kept", leds, 16'h00A5);

      strobes_before = strobes;
      transact("unmapped_read_8000", 1'b0, 16'h8000, 16'h0000, 2, 16'h0000, 1'b1);
      transact("unmapped_write_4000", 1'b1, 16'h4000, 16'h7777, 2, 16'h0000, 1'b1);
      transact("unmapped_read_feff", 1'b0, 16'hFEFF, 16'h0000, 2, 16'h0000, 1'b1);
      transact("io_read_ff03", 1'b0, 16'hFF03, 16'h0000, 2, 16'h0000, 1'b1);
      transact("io_write_ff03", 1'b1, 16'hFF03, 16'h2222, 2, 16'h0000, 1'b1);
      transact("unmapped_read_ff04", 1'b0, 16'hFF04, 16'h0000, 2, 16'h0000, 1'b1);
      check("unmapped_no_strobe", strobes, strobes_before);
      check("unmapped_leds_kept", leds, 16'h00A5);

      issue(1'b0, 16'h0010, 16'h0000);
      await_response(lat, data, err);
      check("stall_latency", lat, 3);
      check("stall_first_data", data, 16'h1234);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("stall_valid", response_valid, 1'b1);
         check("stall_data", response_read_data, 16'h1234);
         check("stall_request_ready", request_ready, 1'b0);
      end
      release_response();
      check("stall_release_idle", request_ready, 1'b1);
      check("stall_release_valid", response_valid, 1'b0);

      issue(1'b0, 16'h0010, 16'h0000);
      @(posedge clock); #1;
      check("wait_state_not_ready", request_ready, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("reset_wait_ready", request_ready, 1'b1);
      check("reset_wait_valid", response_valid, 1'b0);
      check("reset_wait_leds", leds, 16'h0000);
      repeat (3) @(posedge clock);
      #1;
      check("reset_wait_dropped", response_valid, 1'b0);

      strobes_before = strobes;
      issue(1'b1, 16'h0020, 16'h5555);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("reset_access_no_strobe", strobes, strobes_before);
      transact("reset_access_read", 1'b0, 16'h0020, 16'h0000, 3, 16'h0000, 1'b0);

`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      transact("counter_first", 1'b0, 16'hFF02, 16'h0000, 2, 16'h0001, 1'b0);
      repeat (65533) @(posedge clock);
      #1;
      transact("counter_wrapped", 1'b0, 16'hFF02, 16'h0000, 2, 16'h0001, 1'b0);
      transact("counter_write", 1'b1, 16'hFF02, 16'h3333, 2, 16'h0000, 1'b1);
`else
      transact("counter_absent", 1'b0, 16'hFF02, 16'h0000, 2, 16'h0000, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

- Serves the CPU controller's memory accesses: instruction fetches, loads and stores.
- Sits between the datapath's memory request port and a single-port synchronous block RAM.
- Decodes a small memory-mapped I/O window for LEDs, switches and an optional cycle counter.
- Uses a valid/ready request/response handshake, so the controller can wait out variable latency.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width of data and addresses.
- `RAM_ADDRESS_WIDTH`, 14, RAM word-address width; RAM occupies `0 .. 2**RAM_ADDRESS_WIDTH-1`.
- `IO_BASE`, 16'hFF00, first I/O address; I/O window is `IO_BASE .. IO_BASE+3`.

Ports:
- `clock`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `request_valid`  in  1  CPU presents a request.
- `request_ready`  out  1  responder can accept a request.
- `request_write`  in  1  1 = store, 0 = read/fetch.
- `request_address`  in  16  word address.
- `request_write_data`  in  16  store data.
- `response_valid`  out  1  response is available.
- `response_ready`  in  1  CPU consumes the response.
- `response_read_data`  out  16  load data; 0 for writes and errors.
- `response_error`  out  1  unmapped address or write to a read-only register.
- `ram_address`  out  `RAM_ADDRESS_WIDTH`  RAM address.
- `ram_write_enable`  out  1  RAM write strobe.
- `ram_write_data`  out  16  RAM write data.
- `ram_read_data`  in  16  RAM output; valid the cycle after the address is presented.
- `switches`  in  16  board switches.
- `leds`  out  16  LED register.

## Operation
- The FSM states are IDLE, ACCESS, WAIT and RESPOND.
- IDLE:
  - `request_ready`=1.
  - On `request_valid`, latch write, address and data, then go to ACCESS.
- ACCESS:
  - RAM region:
    - `ram_address` = latched address; `ram_write_enable` = latched write.
    - A read goes to WAIT; a write goes to RESPOND.
  - I/O region:
    - Write to `IO_BASE+0` loads `leds`.
    - Read of `IO_BASE+0` returns `leds`.
    - Read of `IO_BASE+1` returns `switches`.
    - Read of `IO_BASE+2` returns the cycle counter.
    - `IO_BASE+3`, writes to +1 and writes to +2 are errors.
    - Read data is captured at the end of ACCESS; the state then goes to RESPOND.
  - Unmapped region (above RAM, below `IO_BASE`, or above `IO_BASE+3`): error; go to RESPOND.
- WAIT: capture `ram_read_data` into the response register; go to RESPOND.
- RESPOND:
  - `response_valid`=1; data and error stay stable.
  - On `response_ready`, go to IDLE.
- Only one request is outstanding at a time; `request_ready`=0 in every state except IDLE.
- Errored writes have no side effect; errored reads return 0.
- `ram_write_enable` is 0 in every state except ACCESS.

## Timing
- Reset values:
  - state IDLE; `request_ready`=1; `response_valid`=0; `response_read_data`=0; `response_error`=0.
  - `ram_address`=0; `ram_write_enable`=0; `ram_write_data`=0; `leds`=0; counter=0.
- Latency, counted from the accept edge (cycle T) to the first cycle with `response_valid` high:
  - RAM read: T+3.
  - RAM write, I/O access, error: T+2.
- With `response_ready` held high, RAM-read throughput is one request per 4 cycles; all others are one per 3.
- A write is visible to reads in the next transaction; the LED output updates at the end of ACCESS.
- `response_valid` held with `response_ready`=0 stalls indefinitely; no timeout.
- `request_valid` outside IDLE is ignored; the CPU must hold it until accepted.
- Reset asserted in any state returns to IDLE next edge, drops the in-flight request, and clears `leds`; no RAM write occurs in the reset cycle.
- Counter: 16-bit, +1 every non-reset cycle, wraps FFFF→0000; a read returns the value during ACCESS.

## Configuration
- `MEMORY_RESPONDER_CYCLE_COUNTER_EN` defined: the counter exists, and `IO_BASE+2` reads it.
- Undefined: no counter register; `IO_BASE+2` reads 0 and is flagged as an error, same as `IO_BASE+3`.

## Structure
- Shared package holds:
  - the state encoding (IDLE/ACCESS/WAIT/RESPOND);
  - I/O offsets (LED=0, SWITCH=1, COUNTER=2);
  - the default `IO_BASE`.
- Sub-module: `memory_address_decoder`, combinational, with outputs is_ram, is_io, io_offset and error from address+write.
- FSM, response register, LED register and counter live in the top module.

## Test plan
- Write 0x1234 to address 0x0010, then read 0x0010:
  - write response at T+2 with error=0;
  - read response at T+3 with data 0x1234.
- Write 0x00A5 to 0xFF00, then read 0xFF00:
  - `leds`=0x00A5 after ACCESS;
  - read returns 0x00A5.
- `switches`=0xBEEF, read 0xFF01 → data 0xBEEF at T+2. Then write 0xFF01 → error=1 and `leds` unchanged.
- Read 0x8000 (unmapped at default width) → error=1, data 0, and no RAM strobe.
- Hold `response_ready`=0 for 5 cycles → `response_valid` and data stay stable and `request_ready` stays 0. Then release → IDLE next cycle.
- Counter and reset:
  - assert reset in WAIT → IDLE, `response_valid`=0, `leds`=0;
  - with EN, after 0x10000 cycles the counter reads back near 0 (wrap);
  - without EN, reading 0xFF02 returns 0 with error=1.
